xor_stream_unit: RTL and testbench
==================================

XOR_STREAM_UNIT -- requirements
Module: xor_stream_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: data, key and keystream width in bits (legal range 4..64).
REQ-002 SHALL provide parameter TAPS, default 8'hB8: Galois LFSR feedback mask, WIDTH bits wide.
REQ-003 SHALL provide parameter CNT_W, default 16: width of the processed-word counter.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 en  input  1  block enable; low blocks new accepts.
REQ-008 mode  input  1  0 = static key XOR, 1 = LFSR keystream XOR.
REQ-009 key_load  input  1  one-cycle strobe that loads key_in into the key register and the LFSR state.
REQ-010 key_in  input  WIDTH  key / LFSR seed.
REQ-011 in_valid  input  1  input word valid.
REQ-012 in_ready  output  1  input word can be accepted.
REQ-013 in_data  input  WIDTH  plaintext or ciphertext word.
REQ-014 out_valid  output  1  output register holds a result.
REQ-015 out_ready  input  1  downstream accepts the result.
REQ-016 out_data  output  WIDTH  in_data XOR keystream word.
REQ-017 word_cnt  output  CNT_W  count of accepted words; saturates at all-ones.

Function
REQ-018 in_ready SHALL equal en AND (NOT out_valid OR out_ready): a one-entry pipeline register with a same-cycle pass-through on drain.
REQ-019 A word SHALL be accepted on a rising edge where in_valid AND in_ready are both high.
REQ-020 On accept, out_data SHALL register in_data XOR K: K = key register when mode=0, or the LFSR state when mode=1; mode is sampled at accept.
REQ-021 Latency SHALL be exactly 1 cycle from accept to out_valid high.
REQ-022 out_valid SHALL set on accept and clear on an out_ready handshake with no simultaneous accept; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 LFSR step (Galois, right shift): if state[0]=1, next = (state>>1) XOR TAPS; otherwise next = state>>1.
REQ-024 The LFSR SHALL step only on an accept with mode=1; it SHALL hold otherwise.
REQ-025 key_load SHALL write key_in to the key register and to the LFSR; a zero key_in SHALL load the LFSR with 1 to avoid lock-up, while the key register takes 0.
REQ-026 key_load and accept in the same cycle: the accepted word SHALL use the old key/LFSR, and the load SHALL take priority over the LFSR step.
REQ-027 en low SHALL block accepts only; a pending output SHALL still drain via out_ready.
REQ-028 word_cnt SHALL increment by 1 per accept and saturate at 2^CNT_W-1; key_load SHALL NOT clear it.

Reset
REQ-029 rst_n low SHALL asynchronously clear out_valid, out_data, key register and word_cnt to 0, and set the LFSR to 1.
REQ-030 Reset mid-transfer SHALL discard the pending output word; there is no recovery of in-flight data.
REQ-031 The first accept after rst_n deasserts SHALL be possible on the first clock edge.

Structure
REQ-032 A shared package SHALL hold the mode constants (MODE_STATIC=0, MODE_LFSR=1) and the default TAPS masks for WIDTH 8, 16 and 32.
REQ-033 The LFSR SHALL be a sub-module lfsr_galois (parameters WIDTH, TAPS; ports clk, rst_n, load, seed, step, state).
REQ-034 The datapath XOR SHALL be purely combinational into the single output register; no other storage.

Verification (WIDTH=8, TAPS=8'hB8)
REQ-035 key_load with key_in=0x5A, mode=0, in_data=0xFF -> out_data=0xA5 one cycle later; word_cnt=1.
REQ-036 key_load 0x01, mode=1, three accepts of 0x00 -> out_data 0x01, 0xB8, 0x5C in order.
REQ-037 out_ready held low for 3 cycles with out_valid=1 -> in_ready=0 and out_data stable; out_ready high with in_valid high -> drain and accept in the same cycle, no bubble.
REQ-038 key_load 0x00 in mode=1 then accept 0x00 -> out_data=0x01.
REQ-039 key_load 0x33 coincident with accept of 0x10 (old key 0x5A, mode=0) -> output 0x4A; next accept of 0x10 -> output 0x23.
REQ-040 Assert rst_n low while out_valid=1 and en=0 -> out_valid=0 immediately; in_ready stays 0 until en is high.

Source files
------------

// File: rtl/xor_stream_unit_pkg.sv
// Shared constants for the XOR stream unit: mode encodings and default
// Galois LFSR feedback masks for the common data widths.
package xor_stream_unit_pkg;

    localparam logic MODE_STATIC = 1'b0;
    localparam logic MODE_LFSR   = 1'b1;

    // Right-shift Galois masks (maximal-length polynomials)
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

endpackage

// File: rtl/xor_stream_unit_lfsr_galois.sv
// Right-shifting Galois LFSR with synchronous seed load. A zero seed is
// replaced by 1 so the register can never lock up in the all-zero state.
module lfsr_galois
    import xor_stream_unit_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W8)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] shifted;

    // Next-state selection: load wins over step, otherwise hold
    always_comb begin
        shifted = state_q >> 1;
        state_d = state_q;
        if (load) begin
            state_d = (seed == '0) ? WIDTH'(1) : seed;
        end else if (step) begin
            state_d = state_q[0] ? (shifted ^ TAPS) : shifted;
        end
    end

    // State register, resets to 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WIDTH'(1);
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/xor_stream_unit.sv
// One-entry streaming XOR cipher stage. Each accepted word is XORed with
// either a static key or the current LFSR keystream word and registered;
// the output register drains through a valid/ready handshake and may be
// refilled in the same cycle it drains.
module xor_stream_unit
    import xor_stream_unit_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W8),
    parameter int               CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             key_load,
    input  logic [WIDTH-1:0] key_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] word_cnt
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [WIDTH-1:0] key_q,       key_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] lfsr_state;
    logic [WIDTH-1:0] keystream;
    logic             accept;
    logic             lfsr_step;

    assign in_ready  = en & (~out_valid_q | out_ready);
    assign accept    = in_valid & in_ready;
    assign keystream = (mode == MODE_LFSR) ? lfsr_state : key_q;
    assign lfsr_step = accept & (mode == MODE_LFSR);

    lfsr_galois #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (key_load),
        .seed  (key_in),
        .step  (lfsr_step),
        .state (lfsr_state)
    );

    // Output register, key register and saturating word counter next state
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        key_d       = key_q;
        cnt_d       = cnt_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data ^ keystream;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (key_load) begin
            key_d = key_in;
        end
    end

    // Registers; reset discards any pending output word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            key_q       <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            key_q       <= key_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_xor_stream_unit.sv
// Scoreboard bench for xor_stream_unit (WIDTH=8, TAPS=8'hB8, CNT_W=4).
module tb_xor_stream_unit;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en, mode, key_load, in_valid, out_ready;
    logic [W-1:0]  key_in, in_data;
    logic          in_ready, out_valid;
    logic [W-1:0]  out_data;
    logic [CW-1:0] word_cnt;

    int n_vec = 0;
    int n_err = 0;

    // model state
    logic [W-1:0]  m_key, m_lfsr, m_ks;
    logic [CW-1:0] m_cnt;
    logic          m_ov, m_acc;
    logic [W-1:0]  sb_q[$];
    logic [W-1:0]  sb_exp;

    xor_stream_unit #(.WIDTH(W), .TAPS(8'hB8), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .key_load  (key_load),
        .key_in    (key_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] lfsr_nxt(input logic [W-1:0] s);
        logic [W-1:0] r;
        r = {1'b0, s[W-1:1]};
        if (s[0]) r = r ^ 8'hB8;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor at the falling edge: check against model, then predict the
    // effect of the coming rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_key  = '0;
            m_lfsr = 8'h01;
            m_cnt  = '0;
            m_ov   = 1'b0;
            sb_q.delete();
        end else begin
            chk("out_valid", out_valid, m_ov);
            chk("in_ready", in_ready, en & (~m_ov | out_ready));
            chk("word_cnt", word_cnt, m_cnt);
            m_acc = in_valid & en & (~m_ov | out_ready);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_pop_empty", 0, 1);
                end else begin
                    sb_exp = sb_q.pop_front();
                    chk("sb_data", out_data, sb_exp);
                end
            end
            m_ks = mode ? m_lfsr : m_key;
            if (m_acc) begin
                sb_q.push_back(in_data ^ m_ks);
                if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
            end
            if (m_acc) m_ov = 1'b1;
            else if (out_ready) m_ov = 1'b0;
            if (key_load) begin
                m_key  = key_in;
                m_lfsr = (key_in == 0) ? 8'h01 : key_in;
            end else if (m_acc && mode) begin
                m_lfsr = lfsr_nxt(m_lfsr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; en = 1; mode = 0; key_load = 0; key_in = 0;
        in_valid = 0; in_data = 0; out_ready = 1;
        #22;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_word_cnt", word_cnt, 0);
        tick();
        rst_n = 1;

        // static key 0x5A on 0xFF
        key_load = 1; key_in = 8'h5A; tick();
        key_load = 0; mode = 0; in_valid = 1; in_data = 8'hFF; tick();
        in_valid = 0;
        chk("static_data", out_data, 8'hA5);
        chk("static_cnt", word_cnt, 1);

        // LFSR keystream from seed 0x01
        mode = 1; key_load = 1; key_in = 8'h01; tick();
        key_load = 0; in_valid = 1; in_data = 8'h00;
        tick(); chk("lfsr_w0", out_data, 8'h01);
        tick(); chk("lfsr_w1", out_data, 8'hB8);
        tick(); chk("lfsr_w2", out_data, 8'h5C);
        in_valid = 0; tick();

        // backpressure then simultaneous drain+accept (key reg = 0x01)
        mode = 0; out_ready = 0; in_valid = 1; in_data = 8'h11; tick();
        in_data = 8'h22;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_stable", out_data, 8'h10);
            tick();
        end
        out_ready = 1; #1;
        chk("drain_in_ready", in_ready, 1);
        tick();
        chk("drain_valid", out_valid, 1);
        chk("drain_data", out_data, 8'h23);
        in_valid = 0; tick();
        chk("drain_empty", out_valid, 0);

        // zero seed
        mode = 1; key_load = 1; key_in = 8'h00; tick();
        key_load = 0; in_valid = 1; in_data = 8'h00; tick();
        chk("zero_seed", out_data, 8'h01);
        mode = 0; in_data = 8'h3C; tick();
        chk("zero_key", out_data, 8'h3C);
        in_valid = 0; tick();

        // key_load coincident with accept, static mode
        key_load = 1; key_in = 8'h5A; tick();
        key_in = 8'h33; in_valid = 1; in_data = 8'h10; tick();
        chk("kl_old_key", out_data, 8'h4A);
        key_load = 0; tick();
        chk("kl_new_key", out_data, 8'h23);
        in_valid = 0; tick();

        // key_load coincident with accept, LFSR mode: load beats step
        mode = 1; key_load = 1; key_in = 8'h07; tick();
        key_in = 8'h40; in_valid = 1; in_data = 8'h00; tick();
        chk("kl_old_lfsr", out_data, 8'h07);
        key_load = 0; tick();
        chk("kl_new_lfsr", out_data, 8'h40);
        in_valid = 0; tick();

        // random traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            en        = ($urandom_range(0, 7) != 0);
            mode      = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            key_load  = ($urandom_range(0, 15) == 0);
            key_in    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            tick();
        end
        key_load = 0; in_valid = 0; out_ready = 1; en = 1;
        tick(); tick();
        chk("cnt_saturated", word_cnt, 4'hF);

        // reset while a word is pending and en is low
        mode = 0; in_valid = 1; in_data = 8'h55; out_ready = 0; tick();
        en = 0; in_valid = 0; tick();
        chk("pend_valid", out_valid, 1);
        rst_n = 0; #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_cnt", word_cnt, 0);
        chk("rst_in_ready", in_ready, 0);
        tick();
        rst_n = 1; tick();
        chk("en_low_ready0", in_ready, 0);
        tick();
        chk("en_low_ready1", in_ready, 0);
        en = 1; #1;
        chk("en_high_ready", in_ready, 1);

        // accept on the first edge after reset release
        rst_n = 0; tick();
        rst_n = 1; en = 1; out_ready = 1; in_valid = 1; in_data = 8'h3C; tick();
        in_valid = 0;
        chk("first_edge_valid", out_valid, 1);
        chk("first_edge_data", out_data, 8'h3C);
        chk("first_edge_cnt", word_cnt, 1);
        tick(); tick();
        chk("sb_final_depth", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
